// File: rtl/sap_operand_regfile_if.sv
// rtl/sap_operand_regfile_if.sv - bus/ALU-side signal bundle for the operand register file
interface sap_operand_regfile_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [WIDTH-1:0]  BusIn;
    logic [2:0]        op;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  ALUInA;
    logic [WIDTH-1:0]  ALUInB;
    logic              carry;
    logic              zero;

    modport master (
        output BusIn, op, waddr, raddr_a, raddr_b,
        input  ALUInA, ALUInB, carry, zero
    );

    modport slave (
        input  BusIn, op, waddr, raddr_a, raddr_b,
        output ALUInA, ALUInB, carry, zero
    );
endinterface

// File: rtl/sap_operand_regfile.sv
// rtl/sap_operand_regfile.sv - NUM_REGS x WIDTH operand register bank with in-place ALU-style ops
module sap_operand_regfile #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
) (
    input logic                  clk,
    input logic                  rst,
    sap_operand_regfile_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_CLR  = 3'b010,
        OP_INC  = 3'b011,
        OP_DEC  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_SWAP = 3'b111
    } op_e;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] rd_w;
    logic             hit_a;
    logic             hit_w;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             upd;
    logic             swap_en;
    logic             carry_q;
    logic             zero_q;

    // Address decode by explicit match: out-of-range indices hit nothing and read as 0.
    always_comb begin
        rd_a  = '0;
        rd_b  = '0;
        rd_w  = '0;
        hit_a = 1'b0;
        hit_w = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.raddr_a == ADDR_W'(i)) begin
                rd_a  = regs[i];
                hit_a = 1'b1;
            end
            if (bus.raddr_b == ADDR_W'(i)) begin
                rd_b = regs[i];
            end
            if (bus.waddr == ADDR_W'(i)) begin
                rd_w  = regs[i];
                hit_w = 1'b1;
            end
        end
    end

    always_comb begin
        res     = rd_w;
        res_c   = 1'b0;
        upd     = hit_w;
        swap_en = 1'b0;
        case (bus.op)
            OP_HOLD: upd = 1'b0;
            OP_LOAD: res = bus.BusIn;
            OP_CLR:  res = '0;
            OP_INC:  {res_c, res} = {1'b0, rd_w} + (WIDTH + 1)'(1);
            OP_DEC: begin
                res   = rd_w - WIDTH'(1);
                res_c = (rd_w == '0);
            end
            OP_SHL: begin
                res   = {rd_w[WIDTH-2:0], 1'b0};
                res_c = rd_w[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, rd_w[WIDTH-1:1]};
                res_c = rd_w[0];
            end
            OP_SWAP: begin
                // Self-swap writes the unchanged value back, so zero still reflects it.
                res     = rd_a;
                swap_en = hit_w && hit_a;
                upd     = swap_en;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (upd && bus.waddr == ADDR_W'(i)) begin
                    regs[i] <= res;
                end else if (swap_en && bus.raddr_a == ADDR_W'(i)) begin
                    regs[i] <= rd_w;
                end
            end
            if (upd) begin
                carry_q <= res_c;
                zero_q  <= (res == '0);
            end
        end
    end

    assign bus.ALUInA = rd_a;
    assign bus.ALUInB = rd_b;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_sap_operand_regfile.sv
// tb/tb_sap_operand_regfile.sv - self-checking bench for sap_operand_regfile
module tb_sap_operand_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sap_operand_regfile_if #(.WIDTH(8), .NUM_REGS(4)) ia ();
    sap_operand_regfile_if #(.WIDTH(4), .NUM_REGS(3)) ib ();

    sap_operand_regfile #(.WIDTH(8), .NUM_REGS(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    sap_operand_regfile #(.WIDTH(4), .NUM_REGS(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 is the 8-bit/4-reg instance, index 1 the 4-bit/3-reg one.
    int m  [2][4];
    int mc [2];
    int mz [2];

    function automatic int wid(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic int nregs(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int model_rd(input int d, input int idx);
        return (idx < nregs(d)) ? m[d][idx] : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int op, wa, ra, bv, r, v, c, md;
        md = 1 << wid(d);
        if (d == 0) begin
            op = int'(ia.op); wa = int'(ia.waddr); ra = int'(ia.raddr_a); bv = int'(ia.BusIn);
        end else begin
            op = int'(ib.op); wa = int'(ib.waddr); ra = int'(ib.raddr_a); bv = int'(ib.BusIn);
        end
        if (op == 0 || wa >= nregs(d)) return;
        r = m[d][wa];
        v = 0;
        c = 0;
        case (op)
            1: v = bv;
            2: v = 0;
            3: begin v = (r + 1) % md;      c = (r == md - 1) ? 1 : 0; end
            4: begin v = (r + md - 1) % md; c = (r == 0) ? 1 : 0; end
            5: begin v = (r * 2) % md;      c = (r >= md / 2) ? 1 : 0; end
            6: begin v = r / 2;             c = r % 2; end
            default: begin
                if (ra >= nregs(d)) return;
                v = m[d][ra];
                m[d][ra] = r;
            end
        endcase
        m[d][wa] = v;
        mc[d] = c;
        mz[d] = (v == 0) ? 1 : 0;
    endtask

    always @(negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) m[d][i] = 0;
            mc[d] = 0;
            mz[d] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        chk("cmp_a_alua",  int'(ia.ALUInA), model_rd(0, int'(ia.raddr_a)));
        chk("cmp_a_alub",  int'(ia.ALUInB), model_rd(0, int'(ia.raddr_b)));
        chk("cmp_a_carry", int'(ia.carry),  mc[0]);
        chk("cmp_a_zero",  int'(ia.zero),   mz[0]);
        chk("cmp_b_alua",  int'(ib.ALUInA), model_rd(1, int'(ib.raddr_a)));
        chk("cmp_b_alub",  int'(ib.ALUInB), model_rd(1, int'(ib.raddr_b)));
        chk("cmp_b_carry", int'(ib.carry),  mc[1]);
        chk("cmp_b_zero",  int'(ib.zero),   mz[1]);
    end

    task automatic drive(input int d, input int op, input int wa, input int ra, input int rb, input int bv);
        if (d == 0) begin
            ia.op = 3'(op); ia.waddr = 2'(wa); ia.raddr_a = 2'(ra); ia.raddr_b = 2'(rb); ia.BusIn = 8'(bv);
        end else begin
            ib.op = 3'(op); ib.waddr = 2'(wa); ib.raddr_a = 2'(ra); ib.raddr_b = 2'(rb); ib.BusIn = 4'(bv);
        end
    endtask

    // Apply one op at the next rising edge, then return to HOLD 2 ns after that edge.
    task automatic step(input int d, input int op, input int wa, input int ra, input int rb, input int bv);
        drive(d, op, wa, ra, rb, bv);
        @(posedge clk);
        #2;
        if (d == 0) ia.op = 3'd0;
        else        ib.op = 3'd0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_alua",  int'(ia.ALUInA), 0);
        chk("rst_alub",  int'(ia.ALUInB), 0);
        chk("rst_carry", int'(ia.carry),  0);
        chk("rst_zero",  int'(ia.zero),   0);
        rst = 1'b1;

        step(0, 1, 1, 1, 0, 'h3A);
        chk("load_3a",      int'(ia.ALUInA), 'h3A);
        chk("load_3a_zero", int'(ia.zero),   0);

        drive(0, 1, 1, 1, 0, 'h77);
        #1;
        chk("no_bypass", int'(ia.ALUInA), 'h3A);
        @(posedge clk);
        #2;
        ia.op = 3'd0;
        chk("load_77", int'(ia.ALUInA), 'h77);

        step(0, 1, 2, 2, 0, 'hFF);
        step(0, 3, 2, 2, 0, 0);
        chk("inc_wrap",   int'(ia.ALUInA), 'h00);
        chk("inc_carry",  int'(ia.carry),  1);
        chk("inc_zero",   int'(ia.zero),   1);
        step(0, 4, 2, 2, 0, 0);
        chk("dec_wrap",   int'(ia.ALUInA), 'hFF);
        chk("dec_borrow", int'(ia.carry),  1);
        chk("dec_zero",   int'(ia.zero),   0);
        step(0, 4, 2, 2, 0, 0);
        chk("dec_fe",     int'(ia.ALUInA), 'hFE);
        chk("dec_nocarry", int'(ia.carry), 0);

        step(0, 1, 0, 0, 0, 'h81);
        step(0, 5, 0, 0, 0, 0);
        chk("shl_val",   int'(ia.ALUInA), 'h02);
        chk("shl_carry", int'(ia.carry),  1);
        step(0, 6, 0, 0, 0, 0);
        chk("shr_val",   int'(ia.ALUInA), 'h01);
        chk("shr_carry", int'(ia.carry),  0);
        step(0, 6, 0, 0, 0, 0);
        chk("shr_zero_val", int'(ia.ALUInA), 'h00);
        chk("shr_carry1",   int'(ia.carry),  1);
        chk("shr_zero",     int'(ia.zero),   1);

        step(0, 1, 0, 0, 0, 'h11);
        step(0, 1, 3, 3, 0, 'hC4);
        step(0, 7, 0, 3, 0, 0);
        chk("swap_reg3",  int'(ia.ALUInA), 'h11);
        chk("swap_carry", int'(ia.carry),  0);
        ia.raddr_a = 2'd0;
        ia.raddr_b = 2'd3;
        #1;
        chk("swap_reg0_a", int'(ia.ALUInA), 'hC4);
        chk("swap_reg3_b", int'(ia.ALUInB), 'h11);
        step(0, 7, 2, 2, 0, 0);
        chk("selfswap_val",  int'(ia.ALUInA), 'hFE);
        chk("selfswap_zero", int'(ia.zero),   0);
        ia.raddr_a = 2'd0;
        ia.raddr_b = 2'd0;
        #1;
        chk("dual_a", int'(ia.ALUInA), 'hC4);
        chk("dual_b", int'(ia.ALUInB), 'hC4);

        step(1, 1, 0, 0, 0, 'hF);
        chk("b_load_f", int'(ib.ALUInA), 'hF);
        step(1, 2, 1, 1, 0, 0);
        chk("b_clr_zero", int'(ib.zero), 1);
        step(1, 1, 3, 3, 0, 'hF);
        chk("b_oor_zero",  int'(ib.zero),   1);
        chk("b_oor_carry", int'(ib.carry),  0);
        chk("b_oor_read",  int'(ib.ALUInA), 0);
        step(1, 3, 0, 0, 0, 0);
        chk("b_inc_wrap",  int'(ib.ALUInA), 0);
        chk("b_inc_carry", int'(ib.carry),  1);
        chk("b_inc_zero",  int'(ib.zero),   1);
        step(1, 1, 2, 2, 0, 'h9);
        step(1, 7, 3, 2, 0, 0);
        chk("b_oor_swap_keep", int'(ib.ALUInA), 'h9);
        chk("b_oor_swap_flag", int'(ib.zero),   0);

        @(posedge clk);
        #2;
        drive(0, 1, 1, 1, 3, 'h5A);
        drive(1, 1, 2, 2, 0, 'h7);
        #5;
        rst = 1'b0;
        #1;
        chk("arst_a_alua", int'(ia.ALUInA), 0);
        chk("arst_a_alub", int'(ia.ALUInB), 0);
        chk("arst_b_alua", int'(ib.ALUInA), 0);
        chk("arst_a_zero", int'(ia.zero),   0);
        @(posedge clk);
        #2;
        ia.op = 3'd0;
        ib.op = 3'd0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("arst_noload_a", int'(ia.ALUInA), 0);
        chk("arst_noload_b", int'(ib.ALUInA), 0);

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
